// File: rtl/h_act_pipe_array.sv
`default_nettype none
// =============================================================================
// Module   : h_act_pipe_array
// Purpose  : Offset-binary accumulator sums -> unipolar activation codes
//            (hardtanh / ReLU / sigmoid), LANES shared units stepped over the
//            channels with valid/ready on both sides.
//            Optional saturation counter: define HACT_SATCNT_EN.
// Revision : 1.0
// =============================================================================
module h_act_pipe_array #(
    parameter int IDIM  = 16,
    parameter int IWID  = 16,
    parameter int ADIM  = 32,
    parameter int OWID  = 8,
    parameter int LANES = 4,
    parameter int ODIM  = IDIM
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [1:0]                mode,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [IDIM-1:0][IWID-1:0] iData,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ODIM-1:0][OWID-1:0] oData,
`ifdef HACT_SATCNT_EN
    input  logic                      sat_clr,
    output logic [15:0]               sat_cnt,
`endif
    output logic                      busy
);

    localparam int c_nbeat = IDIM / LANES;
    localparam int c_bw    = (c_nbeat > 1) ? $clog2(c_nbeat) : 1;

    localparam logic [IWID-1:0] c_pzer = IWID'(ADIM * (2 ** OWID) / 2);
    localparam logic [IWID-1:0] c_ppon = IWID'(ADIM * (2 ** OWID) / 2 + 2 ** (OWID - 1));
    localparam logic [IWID-1:0] c_pnon = IWID'(ADIM * (2 ** OWID) / 2 - 2 ** (OWID - 1));
    localparam logic [OWID-1:0] c_half = OWID'(2 ** (OWID - 1));
    localparam logic [c_bw-1:0] c_last = c_bw'(c_nbeat - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PROC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   w_accept;

    // Buffers are shaped [beat][lane] so a beat selects one LANES-wide slice.
    logic [c_nbeat-1:0][LANES-1:0][IWID-1:0] r_ibuf;
    logic [c_nbeat-1:0][LANES-1:0][OWID-1:0] r_obuf;
    logic [1:0]                              r_mode;
    logic [c_bw-1:0]                         r_beat;
    logic [LANES-1:0][OWID-1:0]              w_code;

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_PROC;
                end
            end
            S_PROC: begin
                busy = 1'b1;
                if (r_beat == c_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------ activation lanes
    generate
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            logic [IWID-1:0] w_x;
            logic [OWID-1:0] w_lo_half;
            logic [OWID-1:0] w_lane;

            assign w_x       = r_ibuf[r_beat][l];
            assign w_lo_half = w_x[OWID-1:0] + c_half;

            always_comb begin
                w_lane = w_lo_half;
                if (w_x >= c_ppon) begin
                    w_lane = '1;
                end else if ((r_mode == 2'd1) && (w_x <= c_pzer)) begin
                    w_lane = c_half;
                end else if ((r_mode != 2'd1) && (w_x <= c_pnon)) begin
                    w_lane = '0;
                end else if (r_mode == 2'd2) begin
                    w_lane = {1'b1, w_x[OWID-1:1]};
                end
            end

            assign w_code[l] = w_lane;
        end
    endgenerate

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ibuf <= '0;
            r_obuf <= '0;
            r_mode <= 2'd0;
            r_beat <= '0;
        end else if (w_accept) begin
            r_ibuf <= iData;
            r_mode <= mode;
            r_beat <= '0;
        end else if (r_state == S_PROC) begin
            r_obuf[r_beat] <= w_code;
            r_beat         <= (r_beat == c_last) ? '0 : r_beat + 1'b1;
        end
    end

    assign oData = r_obuf;

`ifdef HACT_SATCNT_EN
    // ------------------------------------------------- saturation counter
    localparam int c_nw = $clog2(LANES + 1);

    logic [LANES-1:0] w_sat;
    logic [c_nw-1:0]  w_nsat;
    logic [16:0]      w_sat_sum;
    logic [15:0]      r_sat_cnt;

    generate
        for (genvar l = 0; l < LANES; l++) begin : g_sat
            // Both clamp branches count, including ReLU's HALF floor.
            assign w_sat[l] = (g_lane[l].w_x >= c_ppon) ||
                              (g_lane[l].w_x <= ((r_mode == 2'd1) ? c_pzer : c_pnon));
        end
    endgenerate

    always_comb begin
        w_nsat = '0;
        for (int l = 0; l < LANES; l++) begin
            w_nsat = w_nsat + c_nw'(w_sat[l]);
        end
        w_sat_sum = {1'b0, r_sat_cnt} + 17'(w_nsat);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat_cnt <= 16'd0;
        end else if (sat_clr) begin
            r_sat_cnt <= 16'd0;
        end else if (r_state == S_PROC) begin
            r_sat_cnt <= w_sat_sum[16] ? 16'hFFFF : w_sat_sum[15:0];
        end
    end

    assign sat_cnt = r_sat_cnt;
`endif

endmodule
`default_nettype wire
